// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUControl codes, execute FSM states and op-class helpers.
// The ALU decoder uses the same code constants.
package alu_pkg;

  localparam int WIDTH = 32;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } alu_state_t;

  function automatic logic is_shift(input logic [3:0] code);
    return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU ops. Shift codes and unused codes yield 0 here;
// shifts are handled by the serial shifter in the wrapper.
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  logic lt_s, lt_u;

  assign lt_s = $signed(a) < $signed(b);
  assign lt_u = a < b;

  always_comb begin
    y = '0;
    case (alu_ctrl)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_XOR:  y = a ^ b;
      ALU_SLT:  y = {{(WIDTH-1){1'b0}}, lt_s};
      ALU_SLTU: y = {{(WIDTH-1){1'b0}}, lt_u};
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/alu_iter_exec.sv
// Execute-stage ALU: single-cycle ops via alu_comb, shifts via a one-bit-per-cycle
// serial shifter, valid/ready on both sides, synchronous flush.
module alu_iter_exec
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int SHW = $clog2(WIDTH);

  alu_state_t       st, st_n;
  logic [WIDTH-1:0] acc, acc_n;
  logic [SHW-1:0]   cnt, cnt_n;
  logic [3:0]       op, op_n;
  logic [WIDTH-1:0] res_n;
  logic             zero_n;
  logic [WIDTH-1:0] comb_y;
  logic [WIDTH-1:0] acc_sh;

  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .alu_ctrl (alu_ctrl),
    .a        (src_a),
    .b        (src_b),
    .y        (comb_y)
  );

  // One-bit step of the latched shift op.
  always_comb begin
    acc_sh = acc;
    case (op)
      ALU_SLL: acc_sh = {acc[WIDTH-2:0], 1'b0};
      ALU_SRL: acc_sh = {1'b0, acc[WIDTH-1:1]};
      ALU_SRA: acc_sh = {acc[WIDTH-1], acc[WIDTH-1:1]};
      default: acc_sh = acc;
    endcase
  end

  always_comb begin
    st_n   = st;
    acc_n  = acc;
    cnt_n  = cnt;
    op_n   = op;
    res_n  = result;
    zero_n = zero;
    if (flush) begin
      // Abort wins over everything; result/zero keep their last value.
      st_n = IDLE;
    end else begin
      case (st)
        IDLE: begin
          if (in_valid) begin
            if (is_shift(alu_ctrl) && (src_b[SHW-1:0] != '0)) begin
              acc_n = src_a;
              cnt_n = src_b[SHW-1:0];
              op_n  = alu_ctrl;
              st_n  = SHIFT;
            end else begin
              res_n  = is_shift(alu_ctrl) ? src_a : comb_y;
              zero_n = (res_n == '0);
              st_n   = DONE;
            end
          end
        end
        SHIFT: begin
          acc_n = acc_sh;
          cnt_n = cnt - SHW'(1);
          if (cnt == SHW'(1)) begin
            res_n  = acc_sh;
            zero_n = (acc_sh == '0);
            st_n   = DONE;
          end
        end
        DONE: begin
          if (out_ready) st_n = IDLE;
        end
        default: st_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st     <= IDLE;
      acc    <= '0;
      cnt    <= '0;
      op     <= ALU_ADD;
      result <= '0;
      zero   <= 1'b1;
    end else begin
      st     <= st_n;
      acc    <= acc_n;
      cnt    <= cnt_n;
      op     <= op_n;
      result <= res_n;
      zero   <= zero_n;
    end
  end

  assign in_ready  = (st == IDLE) && !reset;
  assign out_valid = (st == DONE);

endmodule

// File: tb/tb_alu_iter_exec.sv
// Directed bench for alu_iter_exec: scoreboard of expected result/zero/latency,
// popped when out_valid rises; flush and async-reset scenarios inline.
module tb_alu_iter_exec;
  import alu_pkg::*;

  typedef struct {
    logic [31:0] res;
    logic        z;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [3:0]  alu_ctrl = '0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        in_ready, out_valid, zero;
  logic [31:0] result;
  logic [31:0] last_res;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  alu_iter_exec dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .src_a     (src_a),
    .src_b     (src_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one op, then wait for its result, compare it against the scoreboard,
  // optionally stall the consumer for 'hold' cycles, and retire it.
  task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input int elat, input int hold);
    exp_t        e;
    int          lat;
    bit          bad;
    logic [31:0] r0;
    e.res = er; e.z = (er == 32'h0); e.lat = elat;
    sb.push_back(e);
    alu_ctrl = c; src_a = a; src_b = b; in_valid = 1'b1;
    out_ready = (hold == 0);
    chk("in_ready_idle", {31'h0, in_ready}, 32'h1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    src_a = $urandom; src_b = $urandom; alu_ctrl = 4'($urandom);
    lat = 1; bad = 1'b0;
    while (!out_valid && lat < 40) begin
      if (in_ready) bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    if (in_ready) bad = 1'b1;
    e = sb.pop_front();
    chk("out_valid_seen", {31'h0, out_valid}, 32'h1);
    chk("latency", lat, e.lat);
    chk("result", result, e.res);
    chk("zero", {31'h0, zero}, {31'h0, e.z});
    chk("in_ready_busy", {31'h0, bad}, 32'h0);
    if (hold > 0) begin
      r0 = result; bad = 1'b0;
      repeat (hold) begin
        @(posedge clk); #1;
        if (!out_valid || in_ready || result !== r0) bad = 1'b1;
      end
      chk("hold_stable", {31'h0, bad}, 32'h0);
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("back_idle", {30'h0, out_valid, in_ready}, 32'h1);
    last_res = e.res;
  endtask

  initial begin
    int  n;
    bit  bad;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_result", result, 32'h0);
    chk("rst_zero", {31'h0, zero}, 32'h1);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    @(posedge clk); #1;

    run_op(ALU_ADD,  32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1, 0);
    run_op(ALU_SUB,  32'd5,         32'd5,         32'h0,         1, 0);
    run_op(ALU_SLT,  32'hFFFF_FFFF, 32'h1,         32'h1,         1, 0);
    run_op(ALU_SLTU, 32'hFFFF_FFFF, 32'h1,         32'h0,         1, 0);
    run_op(4'b1011,  32'h1234_5678, 32'h1,         32'h0,         1, 0);
    run_op(ALU_SRA,  32'h8000_0000, 32'd31,        32'hFFFF_FFFF, 32, 0);
    run_op(ALU_SRL,  32'h8000_0000, 32'd31,        32'h1,         32, 0);
    run_op(ALU_SLL,  32'h1,         32'h0,         32'h1,         1, 0);
    run_op(ALU_SLL,  32'h3,         32'hFFFF_FFE4, 32'h30,        5, 0);
    run_op(ALU_AND,  32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1, 10);
    run_op(ALU_OR,   32'h1,         32'h2,         32'h3,         1, 0);

    // flush with in_valid in IDLE: nothing accepted
    alu_ctrl = ALU_ADD; src_a = 32'd1; src_b = 32'd1;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_idle", {30'h0, out_valid, in_ready}, 32'h1);
    chk("flush_idle_res", result, last_res);

    // flush mid-shift: sll 1 by 20, flush raised in cycle 5
    alu_ctrl = ALU_SLL; src_a = 32'h1; src_b = 32'd20; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_flush_busy", {30'h0, out_valid, in_ready}, 32'h0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_shift", {30'h0, out_valid, in_ready}, 32'h1);
    bad = 1'b0;
    for (n = 0; n < 25; n++) begin
      @(posedge clk); #1;
      if (out_valid) bad = 1'b1;
    end
    chk("flush_no_valid", {31'h0, bad}, 32'h0);
    chk("flush_res_kept", result, last_res);
    run_op(ALU_XOR, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00, 1, 0);

    // async reset in SHIFT
    alu_ctrl = ALU_SRA; src_a = 32'h8000_0000; src_b = 32'd31; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("arst_result", result, 32'h0);
    chk("arst_zero", {31'h0, zero}, 32'h1);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("arst_in_ready", {31'h0, in_ready}, 32'h1);
    @(posedge clk); #1;
    run_op(ALU_ADD, 32'd2, 32'd3, 32'd5, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
